reg_bank: RTL
=============

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WORD, default 16, data width in bits.
REQ-002 Parameter DEPTH, default 8, number of registers (2..64).
REQ-003 Parameter BYPASS, default 1, read ports return same-cycle write data when 1.
REQ-004 Parameter ZERO_REG, default 0, register 0 hardwired to zero when 1.
REQ-005 Derived constant AW = clog2(DEPTH), address width.
REQ-006 Clock and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-007 Ports SHALL be as follows:
 - clk  in  1  clock
 - reset  in  1  synchronous active-high reset
 - mem_we  in  1  memory write strobe
 - mem_addr  in  AW  memory write target
 - mem_data  in  WORD  memory write data
 - dp_we  in  1  datapath write strobe
 - dp_addr  in  AW  datapath write target
 - dp_data  in  WORD  datapath write data
 - issue_valid  in  1  load-issue request for issue_addr
 - issue_addr  in  AW  register awaiting memory data
 - issue_ready  out  1  issue accepted this cycle
 - rd_addr_a / rd_addr_b  in  AW  read addresses
 - rd_data_a / rd_data_b  out  WORD  read data
 - rd_busy_a / rd_busy_b  out  1  addressed register pending
 - busy_vec  out  DEPTH  per-register pending flags

Function
REQ-008 Writes SHALL take effect on the rising clk edge; the new value is visible on registered state the following cycle.
REQ-009 When mem_we and dp_we target different addresses, both writes SHALL complete in the same cycle.
REQ-010 When mem_we and dp_we target the same address, mem_data SHALL be written and dp_data discarded.
REQ-011 A register holds its value in every cycle with no accepted write to it.
REQ-012 issue_ready SHALL equal NOT busy[issue_addr], combinational, and SHALL be 0 for an out-of-range issue_addr.
REQ-013 An issue is accepted when issue_valid AND issue_ready; busy[issue_addr] SHALL be set on that edge.
REQ-014 A mem_we write SHALL clear busy[mem_addr] on the same edge.
REQ-015 Accepted issue and mem_we to the same non-busy address in one cycle: data from mem_data is written; busy is set (issue wins).
REQ-016 A dp_we write to a register whose busy flag is set SHALL be suppressed (no data change).
REQ-017 Read ports SHALL be combinational; rd_busy_x SHALL reflect busy[rd_addr_x].
REQ-018 With BYPASS=1, a read to an address written this cycle SHALL return the winning write data (mem over dp, subject to REQ-016); with BYPASS=0, it returns stored value.
REQ-019 Addresses >= DEPTH: writes and issues ignored, reads return 0 with rd_busy 0.
REQ-020 With ZERO_REG=1, register 0 SHALL read 0, ignore writes, never become busy, and issue_ready for address 0 SHALL be 1 with no effect.

Reset
REQ-021 On reset, all registers SHALL become 0 and all busy flags 0; reset overrides any concurrent write or issue.
REQ-022 Reset asserted mid-load SHALL drop pending state; a later mem_we write behaves as an unsolicited write.
REQ-023 During reset, outputs SHALL reflect combinational reads of the current state; no read-port gating.

Structure
REQ-024 The clog2 helper and the WORD default SHALL reside in the shared definitions package.
REQ-025 One sub-module reg_bank_entry (one word plus busy flag with prioritised load) SHALL be instantiated DEPTH times via generate.

Verification
REQ-026 Reset, then mem_we addr 3 data 0x1234 -> next cycle rd_data_a(3)=0x1234, all other reads 0.
REQ-027 mem_we and dp_we both addr 5 (0xAAAA / 0x5555) -> reg5=0xAAAA; repeat with addr 5 / 6 -> reg5=0xAAAA, reg6=0x5555.
REQ-028 issue addr 2 -> busy_vec[2]=1, issue_ready(2)=0; dp_we 2 data 0x0F0F suppressed; mem_we 2 data 0xBEEF -> reg2=0xBEEF, busy cleared.
REQ-029 BYPASS=1: dp_we addr 4 data 0x0042 with rd_addr_b=4 same cycle -> rd_data_b=0x0042; BYPASS=0 -> old value.
REQ-030 ZERO_REG=1, DEPTH=6: mem_we addr 0 data 0xFFFF -> read 0; mem_we addr 7 -> no change, read addr 7 = 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared definitions for the register bank
package reg_bank_pkg;

    localparam int WORD_DEFAULT = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_entry.sv
// rtl/reg_bank_entry.sv - one register word plus its load-pending flag
module reg_bank_entry
    import reg_bank_pkg::*;
#(
    parameter int WORD = WORD_DEFAULT,
    parameter bit ZERO = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_sel,
    input  logic [WORD-1:0] mem_data,
    input  logic            dp_sel,
    input  logic [WORD-1:0] dp_data,
    input  logic            issue_sel,
    output logic [WORD-1:0] data,
    output logic            busy,
    output logic            wr_en,
    output logic [WORD-1:0] wr_data
);

    logic [WORD-1:0] data_q;
    logic            busy_q;

    // Memory return beats the datapath; a pending load locks out datapath writes.
    assign wr_en   = !ZERO && (mem_sel || (dp_sel && !busy_q));
    assign wr_data = mem_sel ? mem_data : dp_data;
    assign data    = ZERO ? '0 : data_q;
    assign busy    = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (wr_en) begin
                data_q <= wr_data;
            end
            // A new issue outranks a same-cycle memory return clearing the flag.
            if (issue_sel && !busy_q && !ZERO) begin
                busy_q <= 1'b1;
            end else if (mem_sel) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - register bank with load scoreboard and dual read ports
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WORD     = WORD_DEFAULT,
    parameter int DEPTH    = 8,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_we,
    input  logic [AW-1:0]    mem_addr,
    input  logic [WORD-1:0]  mem_data,
    input  logic             dp_we,
    input  logic [AW-1:0]    dp_addr,
    input  logic [WORD-1:0]  dp_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    output logic             issue_ready,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WORD-1:0]  rd_data_a,
    output logic [WORD-1:0]  rd_data_b,
    output logic             rd_busy_a,
    output logic             rd_busy_b,
    output logic [DEPTH-1:0] busy_vec
);

    // Slots past DEPTH exist only as constant zero so any address decodes cleanly.
    localparam int SLOTS = 1 << AW;

    logic [WORD-1:0]  slot_data    [SLOTS];
    logic [WORD-1:0]  slot_wr_data [SLOTS];
    logic [SLOTS-1:0] slot_busy;
    logic [SLOTS-1:0] slot_wr_en;
    logic [SLOTS-1:0] slot_ready;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < DEPTH) begin : g_entry
            reg_bank_entry #(
                .WORD (WORD),
                .ZERO (ZERO_REG && (i == 0))
            ) u_entry (
                .clk       (clk),
                .reset     (reset),
                .mem_sel   (mem_we && (mem_addr == AW'(i))),
                .mem_data  (mem_data),
                .dp_sel    (dp_we && (dp_addr == AW'(i))),
                .dp_data   (dp_data),
                .issue_sel (issue_valid && (issue_addr == AW'(i))),
                .data      (slot_data[i]),
                .busy      (slot_busy[i]),
                .wr_en     (slot_wr_en[i]),
                .wr_data   (slot_wr_data[i])
            );
            assign slot_ready[i] = !slot_busy[i];
        end else begin : g_pad
            assign slot_data[i]    = '0;
            assign slot_wr_data[i] = '0;
            assign slot_busy[i]    = 1'b0;
            assign slot_wr_en[i]   = 1'b0;
            assign slot_ready[i]   = 1'b0;
        end
    end

    assign issue_ready = slot_ready[issue_addr];
    assign busy_vec    = slot_busy[DEPTH-1:0];
    assign rd_busy_a   = slot_busy[rd_addr_a];
    assign rd_busy_b   = slot_busy[rd_addr_b];

    always_comb begin
        rd_data_a = slot_data[rd_addr_a];
        rd_data_b = slot_data[rd_addr_b];
        if (BYPASS && slot_wr_en[rd_addr_a]) begin
            rd_data_a = slot_wr_data[rd_addr_a];
        end
        if (BYPASS && slot_wr_en[rd_addr_b]) begin
            rd_data_b = slot_wr_data[rd_addr_b];
        end
    end

endmodule
